// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the synchronous instruction memory,
// and loads the IF/ID register. Handles start-up fill, stalls, redirects and misaligned-target traps.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTN = 32'h0000_0013
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        EX_PC_Branch,
  input  logic [31:0] EX_PC_Target,
  input  logic        ID_Stall,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  input  logic [31:0] imem_rd_data,
  output logic [31:0] IF_Instruction,
  output logic [31:0] IF_PC,
  output logic        IF_Valid,
  output logic        IF_Trap,
  output logic [31:0] IF_Trap_PC,
  output logic [15:0] branch_cnt
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [XLEN-1:0]   pc, pc_nxt;
  logic [XLEN-1:0]   instr_nxt, id_pc_nxt, trap_pc_nxt;
  logic              valid_nxt, trap_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [XLEN-1:0]   pc_plus4;

  assign pc_plus4 = pc + XLEN'(4);

  // State, PC and IF/ID registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state          <= FILL;
      pc             <= RESET_PC;
      IF_Instruction <= NOP_INSTN;
      IF_PC          <= RESET_PC;
      IF_Valid       <= 1'b0;
      IF_Trap        <= 1'b0;
      IF_Trap_PC     <= '0;
      branch_cnt     <= '0;
    end else begin
      state          <= state_nxt;
      pc             <= pc_nxt;
      IF_Instruction <= instr_nxt;
      IF_PC          <= id_pc_nxt;
      IF_Valid       <= valid_nxt;
      IF_Trap        <= trap_nxt;
      IF_Trap_PC     <= trap_pc_nxt;
      branch_cnt     <= cnt_nxt;
    end
  end

  // Next-state, fetch address and IF/ID update; a branch outranks stall and fill
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    instr_nxt   = IF_Instruction;
    id_pc_nxt   = IF_PC;
    valid_nxt   = IF_Valid;
    trap_nxt    = IF_Trap;
    trap_pc_nxt = IF_Trap_PC;
    cnt_nxt     = branch_cnt;
    imem_addr   = pc;
    imem_en     = 1'b1;

    unique case (state)
      FILL, RUN: begin
        if (EX_PC_Branch) begin
          instr_nxt = NOP_INSTN;
          id_pc_nxt = pc;
          valid_nxt = 1'b0;
          if (EX_PC_Target[1:0] != 2'b00) begin
            state_nxt   = TRAP;
            trap_nxt    = 1'b1;
            trap_pc_nxt = EX_PC_Target;
            imem_en     = 1'b0;
          end else begin
            state_nxt = RUN;
            imem_addr = EX_PC_Target;
            pc_nxt    = EX_PC_Target;
            cnt_nxt   = branch_cnt + CNT_W'(1);
          end
        end else if (state == FILL) begin
          // Memory output not yet valid: re-present pc and insert a bubble
          instr_nxt = NOP_INSTN;
          id_pc_nxt = pc;
          valid_nxt = 1'b0;
          state_nxt = RUN;
        end else if (!ID_Stall) begin
          imem_addr = pc_plus4;
          pc_nxt    = pc_plus4;
          instr_nxt = imem_rd_data;
          id_pc_nxt = pc;
          valid_nxt = 1'b1;
        end
      end
      TRAP: begin
        imem_en   = 1'b0;
        instr_nxt = NOP_INSTN;
        valid_nxt = 1'b0;
      end
      default: begin
        state_nxt = FILL;
      end
    endcase

    if (Reset) begin
      imem_addr = RESET_PC;
      imem_en   = 1'b1;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: synchronous memory model plus an IF/ID scoreboard queue.
module tb_if_fetch_stage;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        chk_pc;
  } exp_t;

  logic        Clk;
  logic        Reset;
  logic        EX_PC_Branch;
  logic [31:0] EX_PC_Target;
  logic        ID_Stall;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rd_data;
  logic [31:0] IF_Instruction;
  logic [31:0] IF_PC;
  logic        IF_Valid;
  logic        IF_Trap;
  logic [31:0] IF_Trap_PC;
  logic [15:0] branch_cnt;

  int unsigned vectors;
  int unsigned miscompares;
  logic [15:0] exp_cnt;
  exp_t        sb[$];

  if_fetch_stage dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .EX_PC_Branch   (EX_PC_Branch),
    .EX_PC_Target   (EX_PC_Target),
    .ID_Stall       (ID_Stall),
    .imem_addr      (imem_addr),
    .imem_en        (imem_en),
    .imem_rd_data   (imem_rd_data),
    .IF_Instruction (IF_Instruction),
    .IF_PC          (IF_PC),
    .IF_Valid       (IF_Valid),
    .IF_Trap        (IF_Trap),
    .IF_Trap_PC     (IF_Trap_PC),
    .branch_cnt     (branch_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return 32'hC0DE_0000 ^ a;
  endfunction

  // Synchronous-read instruction memory, output held while disabled
  always @(posedge Clk) begin
    if (imem_en) imem_rd_data <= mem_word(imem_addr);
  end

  function automatic exp_t bub();
    exp_t e;
    e.instr = 32'h0000_0013; e.pc = '0; e.valid = 1'b0; e.chk_pc = 1'b0;
    return e;
  endfunction

  function automatic exp_t ins(input logic [31:0] a);
    exp_t e;
    e.instr = mem_word(a); e.pc = a; e.valid = 1'b1; e.chk_pc = 1'b1;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, push its IF/ID expectation, then compare after the edge
  task automatic step(input logic br, input logic [31:0] tgt, input logic st, input exp_t e);
    exp_t got;
    EX_PC_Branch = br;
    EX_PC_Target = tgt;
    ID_Stall     = st;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    got = sb.pop_front();
    chk("if_valid", 32'(IF_Valid), 32'(got.valid));
    chk("if_instr", IF_Instruction, got.instr);
    if (got.chk_pc) chk("if_pc", IF_PC, got.pc);
  endtask

  task automatic chk_status(input string tag, input logic trap, input logic [31:0] tpc);
    chk({tag, "_trap"}, 32'(IF_Trap), 32'(trap));
    chk({tag, "_trap_pc"}, IF_Trap_PC, tpc);
    chk({tag, "_cnt"}, 32'(branch_cnt), 32'(exp_cnt));
  endtask

  initial begin
    exp_t rb;
    vectors      = 0;
    miscompares  = 0;
    exp_cnt      = '0;
    Reset        = 1'b1;
    EX_PC_Branch = 1'b0;
    EX_PC_Target = '0;
    ID_Stall     = 1'b0;
    rb           = bub();
    rb.chk_pc    = 1'b1;

    // Reset start-up
    repeat (3) step(1'b0, 32'h0, 1'b0, rb);
    chk_status("reset", 1'b0, 32'h0);
    chk("reset_en", 32'(imem_en), 32'h1);
    chk("reset_addr", imem_addr, 32'h0);
    Reset = 1'b0;
    step(1'b0, 32'h0, 1'b0, bub());
    step(1'b0, 32'h0, 1'b0, ins(32'h0));
    step(1'b0, 32'h0, 1'b0, ins(32'h4));

    // Redirect at pc=8 to 0x40
    step(1'b1, 32'h40, 1'b0, bub());
    exp_cnt = 16'd1;
    chk_status("redir", 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b0, ins(32'h40));
    step(1'b0, 32'h0, 1'b0, ins(32'h44));

    // Redirect to 8 to reach IF_PC=12, then stall three cycles
    step(1'b1, 32'h8, 1'b0, bub());
    exp_cnt = 16'd2;
    step(1'b0, 32'h0, 1'b0, ins(32'h8));
    step(1'b0, 32'h0, 1'b0, ins(32'hC));
    repeat (3) step(1'b0, 32'h0, 1'b1, ins(32'hC));
    step(1'b0, 32'h0, 1'b0, ins(32'h10));
    step(1'b0, 32'h0, 1'b0, ins(32'h14));

    // Branch and stall in the same cycle
    step(1'b1, 32'h100, 1'b1, bub());
    exp_cnt = 16'd3;
    chk_status("br_stall", 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b0, ins(32'h100));
    step(1'b0, 32'h0, 1'b0, ins(32'h104));

    // Drive the counter up to 16'hFFFF with back-to-back redirects
    for (int i = 0; i < 65532; i++) begin
      EX_PC_Branch = 1'b1;
      EX_PC_Target = 32'h200;
      ID_Stall     = 1'b0;
      @(posedge Clk);
    end
    #1;
    exp_cnt = 16'hFFFF;
    chk_status("cnt_max", 1'b0, 32'h0);
    step(1'b1, 32'h300, 1'b0, bub());
    exp_cnt = 16'h0000;
    chk_status("cnt_wrap", 1'b0, 32'h0);

    // PC wrap past 32'hFFFF_FFFC
    step(1'b1, 32'hFFFF_FFFC, 1'b0, bub());
    exp_cnt = 16'd1;
    step(1'b0, 32'h0, 1'b0, ins(32'hFFFF_FFFC));
    step(1'b0, 32'h0, 1'b0, ins(32'h0));

    // Misaligned target traps and stays trapped
    EX_PC_Branch = 1'b1;
    EX_PC_Target = 32'h22;
    #1;
    chk("trap_en_now", 32'(imem_en), 32'h0);
    step(1'b1, 32'h22, 1'b0, bub());
    chk_status("trap", 1'b1, 32'h22);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, $urandom, 1'($urandom_range(0, 1)), bub());
      chk("trap_en", 32'(imem_en), 32'h0);
      chk_status("trap_hold", 1'b1, 32'h22);
    end

    // Reset clears the trap and restarts fetch at 0
    Reset = 1'b1;
    step(1'b0, 32'h0, 1'b0, rb);
    exp_cnt = 16'd0;
    chk_status("rst2", 1'b0, 32'h0);
    Reset = 1'b0;
    step(1'b0, 32'h0, 1'b0, bub());
    step(1'b0, 32'h0, 1'b0, ins(32'h0));
    step(1'b0, 32'h0, 1'b0, ins(32'h4));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
